// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream and writes the payload into instruction memory.
// The CPU is released from reset only after a frame's checksum matches.
module prog_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 8,
    parameter logic [7:0]  MAGIC      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   bytes_loaded
);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [ADDR_WIDTH:0]   bytes_q, bytes_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  accept;
    logic                  is_magic;

    assign accept   = in_valid && in_ready;
    assign is_magic = (in_data == MAGIC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bytes_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bytes_q     <= bytes_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Frame-local working registers are re-initialised by the MAGIC/LEN bytes, so they need no reset.
    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        addr_q <= addr_d;
        acc_q  <= acc_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_magic) state_d = S_LEN;
            S_LEN:   if (accept) state_d = S_DATA;
            S_DATA:  if (accept && rem_q == CNT_W'(1)) state_d = S_CSUM;
            S_CSUM:  if (accept) state_d = (in_data == acc_q) ? S_RUN : S_ERR;
            S_RUN:   state_d = S_RUN;
            S_ERR:   if (accept && is_magic) state_d = S_LEN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rem_d       = rem_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        bytes_d     = bytes_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (accept) begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (is_magic) begin
                        acc_d   = '0;
                        bytes_d = '0;
                    end
                end
                S_LEN: begin
                    rem_d  = (in_data == '0) ? FULL : CNT_W'(in_data);
                    addr_d = '0;
                end
                S_DATA: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    acc_d       = acc_q + in_data;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    rem_d       = rem_q - CNT_W'(1);
                    if (bytes_q != FULL) bytes_d = bytes_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state_q != S_RUN);
        cpu_reset  = (state_q != S_RUN);
        load_done  = (state_q == S_RUN);
        load_error = (state_q == S_ERR);
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign bytes_loaded = bytes_q;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected memory writes are queued as frames are sent
// and matched against mem_we pulses observed on the falling clock edge.
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset;
    logic       load_done;
    logic       load_error;
    logic [8:0] bytes_loaded;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_cnt = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  pl[$];
    logic [15:0] mon_e;

    prog_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAGIC(8'hA5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
        .bytes_loaded(bytes_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("write_expected", 32'(exp_q.size()), 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_e[15:8]));
                chk("wr_data", 32'(mem_wdata), 32'(mon_e[7:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit gap);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 1);
        @(posedge clk);
        if (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'hA5;
        end
    endtask

    task automatic drop();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Sends LEN, the bytes in pl, and the checksum; queues the writes the loader should make.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] cs, input bit gap);
        send(len, gap);
        for (int i = 0; i < pl.size(); i++) begin
            exp_q.push_back({8'(i), pl[i]});
            send(pl[i], gap);
        end
        send(cs, gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 1);
        chk({tag, "_load_done"}, 32'(load_done), 0);
        chk({tag, "_load_error"}, 32'(load_error), 0);
        chk({tag, "_bytes"}, 32'(bytes_loaded), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d expected completion", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w0;
        logic [7:0]  sum;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("rst");

        // Normal load
        send(8'hA5, 0);
        pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        send_frame(8'h03, 8'h66, 0);
        drop();
        chk("t1_cpu_reset", 32'(cpu_reset), 0);
        chk("t1_load_done", 32'(load_done), 1);
        chk("t1_load_error", 32'(load_error), 0);
        chk("t1_bytes", 32'(bytes_loaded), 3);
        chk("t1_in_ready", 32'(in_ready), 0);
        chk("t1_hold_we", 32'(mem_we), 0);
        chk("t1_hold_addr", 32'(mem_addr), 2);
        chk("t1_hold_data", 32'(mem_wdata), 32'h33);
        chk("t1_sb_empty", 32'(exp_q.size()), 0);

        // RUN ignores input
        w0 = wr_cnt;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("run_in_ready", 32'(in_ready), 0);
            chk("run_mem_we", 32'(mem_we), 0);
            chk("run_cpu_reset", 32'(cpu_reset), 0);
        end
        in_valid = 1'b0;
        chk("run_writes", 32'(wr_cnt - w0), 0);

        // Checksum error then recovery
        do_reset();
        w0 = wr_cnt;
        send(8'hA5, 0);
        pl.delete(); pl.push_back(8'h10); pl.push_back(8'h20);
        send_frame(8'h02, 8'h31, 0);
        drop();
        chk("t2_load_error", 32'(load_error), 1);
        chk("t2_cpu_reset", 32'(cpu_reset), 1);
        chk("t2_load_done", 32'(load_done), 0);
        chk("t2_in_ready", 32'(in_ready), 1);
        chk("t2_bytes", 32'(bytes_loaded), 2);
        chk("t2_writes", 32'(wr_cnt - w0), 2);
        send(8'hA5, 0);
        drop();
        chk("t2_err_clear", 32'(load_error), 0);
        chk("t2_bytes_clear", 32'(bytes_loaded), 0);
        pl.delete(); pl.push_back(8'h07);
        send_frame(8'h01, 8'h07, 0);
        drop();
        chk("t2_load_done", 32'(load_done), 1);
        chk("t2_load_error2", 32'(load_error), 0);
        chk("t2_sb_empty", 32'(exp_q.size()), 0);

        // Garbage bytes and valid gaps
        do_reset();
        w0 = wr_cnt;
        send(8'h00, 1);
        send(8'hFF, 1);
        send(8'h5A, 1);
        chk("t3_idle_bytes", 32'(bytes_loaded), 0);
        send(8'hA5, 1);
        pl.delete(); pl.push_back(8'h40);
        send_frame(8'h01, 8'h40, 1);
        @(negedge clk);
        chk("t3_load_done", 32'(load_done), 1);
        chk("t3_writes", 32'(wr_cnt - w0), 1);
        chk("t3_bytes", 32'(bytes_loaded), 1);

        // Full-size frame with LEN=0
        do_reset();
        w0 = wr_cnt;
        sum = 8'h00;
        pl.delete();
        for (int i = 0; i < 256; i++) begin
            pl.push_back(8'(i));
            sum = sum + 8'(i);
        end
        send(8'hA5, 0);
        send_frame(8'h00, sum, 0);
        drop();
        repeat (2) @(negedge clk);
        chk("t4_writes", 32'(wr_cnt - w0), 256);
        chk("t4_bytes", 32'(bytes_loaded), 32'h100);
        chk("t4_load_done", 32'(load_done), 1);
        chk("t4_last_addr", 32'(mem_addr), 32'hFF);
        chk("t4_sb_empty", 32'(exp_q.size()), 0);

        // Reset mid-load
        do_reset();
        send(8'hA5, 0);
        send(8'h04, 0);
        exp_q.push_back({8'h00, 8'h01});
        send(8'h01, 0);
        exp_q.push_back({8'h01, 8'h02});
        send(8'h02, 0);
        drop();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("t5");
        chk("t5_sb_empty", 32'(exp_q.size()), 0);
        send(8'hA5, 0);
        pl.delete(); pl.push_back(8'h09);
        send_frame(8'h01, 8'h09, 0);
        drop();
        chk("t5_load_done", 32'(load_done), 1);
        chk("t5_bytes", 32'(bytes_loaded), 1);
        chk("t5_sb_empty2", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
